// File: rtl/encoder_8_to_3_stream.sv
// Sequential 8-to-3 encoder. Takes an 8-bit request vector over a valid/ready
// handshake and streams out the binary index of every set bit, one code per
// transfer, in priority order. Every output is decoded from registered state.
module encoder_8_to_3_stream #(
    parameter bit LOW_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic       a_valid,
    output logic       a_ready,
    output logic [2:0] Y,
    output logic       y_valid,
    input  logic       y_ready,
    output logic       y_last,
    output logic       zero_req,
    output logic [3:0] pend_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] pend;
    logic [7:0] pend_next;
    logic       zero_q;
    logic       zero_next;
    logic [2:0] sel;
    logic [3:0] count;

    // State register, pending bits and the zero-vector pulse flop
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pend   <= '0;
            zero_q <= 1'b0;
        end else begin
            state  <= state_next;
            pend   <= pend_next;
            zero_q <= zero_next;
        end
    end

    // Priority pick of the pending bit to present next; the later loop hit wins
    always_comb begin
        sel = '0;
        if (LOW_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (pend[i]) sel = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pend[i]) sel = 3'(i);
            end
        end
    end

    // Population count of the pending bits
    always_comb begin
        count = '0;
        for (int i = 0; i < 8; i++) begin
            count = count + {3'b000, pend[i]};
        end
    end

    // Next-state logic: leave IDLE on a non-zero accept, return after the last transfer
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (a_valid && (A != 8'h00)) state_next = BUSY;
            BUSY: if (y_ready && (count == 4'd1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pending-bit update: load on accept, clear the presented bit on transfer
    always_comb begin
        pend_next = pend;
        zero_next = 1'b0;
        if (state == IDLE) begin
            if (a_valid) begin
                if (A != 8'h00) pend_next = A;
                else            zero_next = 1'b1;
            end
        end else if (y_ready) begin
            pend_next[sel] = 1'b0;
        end
    end

    // Output decode, purely from registered state
    always_comb begin
        a_ready  = (state == IDLE);
        y_valid  = (state == BUSY);
        Y        = (state == BUSY) ? sel : 3'd0;
        y_last   = (state == BUSY) && (count == 4'd1);
        zero_req = zero_q;
        pend_cnt = count;
    end

endmodule

// File: tb/tb_encoder_8_to_3_stream.sv
// Self-checking bench for encoder_8_to_3_stream. Two instances share the
// stimulus: one highest-first, one lowest-first.
module tb_encoder_8_to_3_stream;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic       a_valid;
    logic       y_ready;

    logic       a_ready_hi, y_valid_hi, y_last_hi, zero_req_hi;
    logic [2:0] y_hi;
    logic [3:0] pend_cnt_hi;
    logic       a_ready_lo, y_valid_lo, y_last_lo, zero_req_lo;
    logic [2:0] y_lo;
    logic [3:0] pend_cnt_lo;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] a;
        int         n;
        logic [2:0] hi[8];
        logic [2:0] lo[8];
    } vec_t;

    vec_t table_v[12];

    encoder_8_to_3_stream #(.LOW_FIRST(1'b0)) dut (
        .clk(clk), .rst(rst), .A(A), .a_valid(a_valid), .a_ready(a_ready_hi),
        .Y(y_hi), .y_valid(y_valid_hi), .y_ready(y_ready), .y_last(y_last_hi),
        .zero_req(zero_req_hi), .pend_cnt(pend_cnt_hi)
    );

    encoder_8_to_3_stream #(.LOW_FIRST(1'b1)) dut_low (
        .clk(clk), .rst(rst), .A(A), .a_valid(a_valid), .a_ready(a_ready_lo),
        .Y(y_lo), .y_valid(y_valid_lo), .y_ready(y_ready), .y_last(y_last_lo),
        .zero_req(zero_req_lo), .pend_cnt(pend_cnt_lo)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] a, input logic av, input logic yr);
        A       = a;
        a_valid = av;
        y_ready = yr;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " a_ready hi"},  8'(a_ready_hi),  8'd1);
        checkOutput({tag, " y_valid hi"},  8'(y_valid_hi),  8'd0);
        checkOutput({tag, " Y hi"},        8'(y_hi),        8'd0);
        checkOutput({tag, " y_last hi"},   8'(y_last_hi),   8'd0);
        checkOutput({tag, " pend_cnt hi"}, 8'(pend_cnt_hi), 8'd0);
        checkOutput({tag, " a_ready lo"},  8'(a_ready_lo),  8'd1);
        checkOutput({tag, " y_valid lo"},  8'(y_valid_lo),  8'd0);
        checkOutput({tag, " pend_cnt lo"}, 8'(pend_cnt_lo), 8'd0);
    endtask

    // Called and returns just after a falling edge; y_ready held high throughout
    task automatic sendVector(input vec_t v);
        string tag;
        applyStimulus(v.a, 1'b1, 1'b1);
        checkOutput($sformatf("v%02h accept a_ready", v.a), 8'(a_ready_hi), 8'd1);
        @(negedge clk);
        applyStimulus(8'h00, 1'b0, 1'b1);
        for (int j = 0; j < v.n; j++) begin
            tag = $sformatf("v%02h code%0d", v.a, j);
            checkOutput({tag, " y_valid"},     8'(y_valid_hi),  8'd1);
            checkOutput({tag, " a_ready"},     8'(a_ready_hi),  8'd0);
            checkOutput({tag, " Y hi"},        8'(y_hi),        8'(v.hi[j]));
            checkOutput({tag, " y_last hi"},   8'(y_last_hi),   (j == v.n - 1) ? 8'd1 : 8'd0);
            checkOutput({tag, " pend_cnt hi"}, 8'(pend_cnt_hi), 8'(v.n - j));
            checkOutput({tag, " zero_req"},    8'(zero_req_hi), 8'd0);
            checkOutput({tag, " Y lo"},        8'(y_lo),        8'(v.lo[j]));
            checkOutput({tag, " y_last lo"},   8'(y_last_lo),   (j == v.n - 1) ? 8'd1 : 8'd0);
            checkOutput({tag, " pend_cnt lo"}, 8'(pend_cnt_lo), 8'(v.n - j));
            @(negedge clk);
        end
        checkIdle($sformatf("v%02h done", v.a));
    endtask

    initial begin
        int   delivered;
        logic rdy;
        vec_t v;

        checks = 0;
        errors = 0;

        // Vector table: one-hot sweep then multi-hot patterns, expected codes by hand
        for (int i = 0; i < 8; i++) begin
            table_v[i].a  = 8'(1 << i);
            table_v[i].n  = 1;
            table_v[i].hi = '{3'(i), 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
            table_v[i].lo = '{3'(i), 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        end
        table_v[8]  = '{a: 8'b1010_0110, n: 4,
                        hi: '{3'd7, 3'd5, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0},
                        lo: '{3'd1, 3'd2, 3'd5, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0}};
        table_v[9]  = '{a: 8'hFF, n: 8,
                        hi: '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0},
                        lo: '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7}};
        table_v[10] = '{a: 8'h81, n: 2,
                        hi: '{3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
                        lo: '{3'd0, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        table_v[11] = '{a: 8'h3C, n: 4,
                        hi: '{3'd5, 3'd4, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0},
                        lo: '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0}};

        // Reset held two cycles while a full vector is offered
        rst = 1'b1;
        applyStimulus(8'hFF, 1'b1, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkIdle("reset");
        checkOutput("reset zero_req", 8'(zero_req_hi), 8'd0);

        // Table-driven vectors
        for (int t = 0; t < 12; t++) begin
            sendVector(table_v[t]);
        end

        // Backpressure on a full vector, with an ignored request during BUSY
        applyStimulus(8'hFF, 1'b1, 1'b1);
        @(negedge clk);
        delivered = 0;
        for (int c = 0; c < 40 && delivered < 8; c++) begin
            rdy = (c % 3 == 0);
            applyStimulus(8'h01, 1'b1, rdy);
            checkOutput($sformatf("bp c%0d y_valid", c),  8'(y_valid_hi),  8'd1);
            checkOutput($sformatf("bp c%0d a_ready", c),  8'(a_ready_hi),  8'd0);
            checkOutput($sformatf("bp c%0d Y hi", c),     8'(y_hi),        8'(7 - delivered));
            checkOutput($sformatf("bp c%0d Y lo", c),     8'(y_lo),        8'(delivered));
            checkOutput($sformatf("bp c%0d pend_cnt", c), 8'(pend_cnt_hi), 8'(8 - delivered));
            checkOutput($sformatf("bp c%0d y_last", c),   8'(y_last_hi),   (delivered == 7) ? 8'd1 : 8'd0);
            @(negedge clk);
            if (rdy) delivered++;
        end
        checkOutput("bp delivered", 8'(delivered), 8'd8);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkIdle("bp done");

        // Zero vector: one-cycle zero_req pulse, no codes
        applyStimulus(8'h00, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("zero pulse hi", 8'(zero_req_hi), 8'd1);
        checkOutput("zero pulse lo", 8'(zero_req_lo), 8'd1);
        checkIdle("zero accept");
        @(negedge clk);
        checkOutput("zero pulse end", 8'(zero_req_hi), 8'd0);
        checkIdle("zero after");

        // Reset in the middle of a vector drops the pending codes
        applyStimulus(8'hF0, 1'b1, 1'b1);
        @(negedge clk);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("midrst code0 Y hi", 8'(y_hi), 8'd7);
        checkOutput("midrst code0 Y lo", 8'(y_lo), 8'd4);
        @(negedge clk);
        checkOutput("midrst code1 Y hi", 8'(y_hi), 8'd6);
        checkOutput("midrst code1 Y lo", 8'(y_lo), 8'd5);
        @(negedge clk);
        checkOutput("midrst pend before", 8'(pend_cnt_hi), 8'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkIdle("midrst after");
        checkOutput("midrst zero_req", 8'(zero_req_hi), 8'd0);

        v = '{a: 8'h08, n: 1,
              hi: '{3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0},
              lo: '{3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
        sendVector(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
